// File: rtl/ps2_pkg.sv
// Shared constants, bit-FSM state encoding and the ps2_key event word layout.
package ps2_pkg;

    localparam int unsigned KEY_W = 11;

    localparam logic [7:0] PS2_E0 = 8'hE0;
    localparam logic [7:0] PS2_F0 = 8'hF0;
    localparam logic [7:0] PS2_E1 = 8'hE1;
    localparam logic [7:0] PS2_FA = 8'hFA;
    localparam logic [7:0] PS2_AA = 8'hAA;
    localparam logic [7:0] PS2_EE = 8'hEE;
    localparam logic [7:0] PS2_FE = 8'hFE;
    localparam logic [7:0] PS2_00 = 8'h00;
    localparam logic [7:0] PS2_FF = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic       toggle;
        logic       pressed;
        logic       ext;
        logic [7:0] code;
    } ps2_key_t;

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 device->host byte receiver: input synchronisers, clock deglitch filter,
// start/data/parity/stop deframing and inter-edge timeout.
module ps2_rx_byte
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 12_000_000,
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT_US = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       err_o
);

    localparam int unsigned TIMEOUT_CYC = TIMEOUT_US * CLK_HZ / 1_000_000;
    localparam int unsigned TO_W        = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned FLT_W       = $clog2(FILTER_LEN + 1);

    logic [1:0]      clk_sync_q, dat_sync_q;
    logic            filt_q, filt_d;
    logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
    rx_state_e       state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_ok_q, par_ok_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            fall_c;
    logic            dat_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            flt_cnt_q  <= '0;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_ok_q   <= 1'b0;
            to_cnt_q   <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            filt_q     <= filt_d;
            flt_cnt_q  <= flt_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_ok_q   <= par_ok_d;
            to_cnt_q   <= to_cnt_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    // Filtered clock only follows the line after FILTER_LEN consecutive differing cycles.
    always_comb begin
        filt_d    = filt_q;
        flt_cnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                flt_cnt_d = flt_cnt_q + FLT_W'(1);
            end
        end
        fall_c = filt_q & ~filt_d;
        dat_s  = dat_sync_q[1];
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_ok_d  = par_ok_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        if (state_q == ST_IDLE || fall_c) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (fall_c && !dat_s) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (fall_c) begin
                    shift_d   = {dat_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall_c) begin
                    par_ok_d = ^{shift_q, dat_s};
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall_c) begin
                    if (dat_s && par_ok_q) begin
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Stalled frame: device stopped clocking mid-byte.
        if (state_q != ST_IDLE && !fall_c && to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end
    end

    assign byte_o  = shift_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: folds E0/F0/E1 prefixes into the 11-bit ps2_key event word.
// Optional PS2_KEY_REPEAT_FILTER_EN drops typematic repeats of the last make code.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 12_000_000,
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT_US = 200
) (
    input  logic             clk_sys,
    input  logic             Reset_I,
    input  logic             ps2_clk_i,
    input  logic             ps2_dat_i,
    output logic [KEY_W-1:0] ps2_key,
    output logic             err_o
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    ps2_rx_byte #(
        .CLK_HZ    (CLK_HZ),
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT_US(TIMEOUT_US)
    ) u_rx (
        .clk      (clk_sys),
        .rst_n    (Reset_I),
        .ps2_clk_i(ps2_clk_i),
        .ps2_dat_i(ps2_dat_i),
        .byte_o   (rx_byte),
        .valid_o  (rx_valid),
        .err_o    (rx_err)
    );

    ps2_key_t   key_q, key_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [2:0] skip_q, skip_d;
    logic       err_q, err_d;
    logic       emit_c;
`ifdef PS2_KEY_REPEAT_FILTER_EN
    logic [8:0] last_q, last_d;
    logic       last_vld_q, last_vld_d;
`endif

    always_ff @(posedge clk_sys or negedge Reset_I) begin
        if (!Reset_I) begin
            key_q      <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            skip_q     <= '0;
            err_q      <= 1'b0;
`ifdef PS2_KEY_REPEAT_FILTER_EN
            last_q     <= '0;
            last_vld_q <= 1'b0;
`endif
        end else begin
            key_q      <= key_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            skip_q     <= skip_d;
            err_q      <= err_d;
`ifdef PS2_KEY_REPEAT_FILTER_EN
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
`endif
        end
    end

    always_comb begin
        key_d  = key_q;
        ext_d  = ext_q;
        brk_d  = brk_q;
        skip_d = skip_q;
        err_d  = rx_err;
        emit_c = 1'b0;
`ifdef PS2_KEY_REPEAT_FILTER_EN
        last_d     = last_q;
        last_vld_d = last_vld_q;
`endif
        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else begin
                case (rx_byte)
                    PS2_E1: skip_d = 3'd7;
                    PS2_E0: ext_d  = 1'b1;
                    PS2_F0: brk_d  = 1'b1;
                    PS2_FA, PS2_AA, PS2_EE, PS2_FE, PS2_00, PS2_FF: begin
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                    default: begin
                        emit_c = 1'b1;
                        ext_d  = 1'b0;
                        brk_d  = 1'b0;
`ifdef PS2_KEY_REPEAT_FILTER_EN
                        if (brk_q) begin
                            last_vld_d = 1'b0;
                        end else if (last_vld_q && last_q == {ext_q, rx_byte}) begin
                            emit_c = 1'b0;
                        end else begin
                            last_d     = {ext_q, rx_byte};
                            last_vld_d = 1'b1;
                        end
`endif
                    end
                endcase
            end
        end
        if (emit_c) begin
            key_d.toggle  = ~key_q.toggle;
            key_d.pressed = ~brk_q;
            key_d.ext     = ext_q;
            key_d.code    = rx_byte;
        end
    end

    assign ps2_key = key_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames, prefix folding, errors, timeout.
module tb_ps2_key_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic [10:0] ps2_key;
    logic        err_o;

    int tests = 0;
    int fails = 0;
    int err_cnt = 0;
    int tog_cnt = 0;
    logic key_prev = 1'b0;

    ps2_key_decoder #(
        .CLK_HZ    (1_000_000),
        .FILTER_LEN(4),
        .TIMEOUT_US(200)
    ) dut (
        .clk_sys  (clk),
        .Reset_I  (rst_n),
        .ps2_clk_i(ps2_clk),
        .ps2_dat_i(ps2_dat),
        .ps2_key  (ps2_key),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    // Count err_o high cycles and toggle-bit flips, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n && err_o) err_cnt <= err_cnt + 1;
        if (rst_n && ps2_key[10] != key_prev) tog_cnt <= tog_cnt + 1;
        key_prev <= ps2_key[10];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_dat = f[i];
            repeat (5) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (15) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (10) @(posedge clk);
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad, b, 1'b0};
        send_bits(f, 11);
        repeat (20) @(posedge clk);
    endtask

    initial begin
        int e0, t0;
        logic [10:0] part;
        repeat (5) @(posedge clk);
        #1;
        check("reset_key", 32'(ps2_key), 32'h0);
        check("reset_err", 32'(err_o), 32'h0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        send_byte(8'h29, 0);
        check("space_key", 32'(ps2_key), 32'h629);
        check("space_noerr", 32'(err_cnt), 32'd0);

        send_byte(8'hE0, 0); send_byte(8'h75, 0);
        check("up_make", 32'(ps2_key), 32'h375);
        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h75, 0);
        check("up_break", 32'(ps2_key), 32'h575);

        send_byte(8'h1C, 1);
        check("badpar_err", 32'(err_cnt), 32'd1);
        check("badpar_key", 32'(ps2_key), 32'h575);
        send_byte(8'hF0, 0); send_byte(8'h1C, 0);
        check("a_break", 32'(ps2_key), 32'h01C);

        // Start bit plus four data bits of 0x16, then the clock stops.
        part = {1'b1, ~^8'h16, 8'h16, 1'b0};
        send_bits(part, 5);
        repeat (400) @(posedge clk);
        check("timeout_err", 32'(err_cnt), 32'd2);
        check("timeout_key", 32'(ps2_key), 32'h01C);
        send_byte(8'h16, 0);
        check("after_timeout", 32'(ps2_key), 32'h616);

        t0 = tog_cnt;
        send_byte(8'hE1, 0); send_byte(8'h14, 0); send_byte(8'h77, 0);
        send_byte(8'hE1, 0); send_byte(8'hF0, 0); send_byte(8'h14, 0);
        send_byte(8'hF0, 0); send_byte(8'h77, 0); send_byte(8'h05, 0);
        check("pause_key", 32'(ps2_key), 32'h205);
        check("pause_toggles", 32'(tog_cnt - t0), 32'd1);

        send_byte(8'hFA, 0);
        check("ack_swallow", 32'(ps2_key), 32'h205);

        send_byte(8'hE0, 0); send_byte(8'hE0, 0); send_byte(8'hF0, 0);
        send_byte(8'hF0, 0); send_byte(8'h74, 0);
        check("idem_prefix", 32'(ps2_key), 32'h574);

        e0 = err_cnt;
        send_byte(8'hE0, 0); send_byte(8'h33, 1); send_byte(8'h6B, 0);
        check("err_clr_flags", 32'(ps2_key), 32'h26B);
        check("err_clr_pulse", 32'(err_cnt - e0), 32'd1);

        t0 = tog_cnt;
        send_byte(8'h1C, 0); send_byte(8'h1C, 0); send_byte(8'h1C, 0);
`ifdef PS2_KEY_REPEAT_FILTER_EN
        check("repeat_toggles", 32'(tog_cnt - t0), 32'd1);
`else
        check("repeat_toggles", 32'(tog_cnt - t0), 32'd3);
`endif
        check("repeat_key", 32'(ps2_key), 32'h61C);
        send_byte(8'hF0, 0); send_byte(8'h1C, 0);
        check("repeat_break", 32'(ps2_key), 32'h01C);
        send_byte(8'h1C, 0);
        check("remake", 32'(ps2_key), 32'h61C);

        e0 = err_cnt;
        part = {1'b1, ~^8'h29, 8'h29, 1'b0};
        send_bits(part, 4);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_key", 32'(ps2_key), 32'h0);
        rst_n = 1'b1;
        repeat (400) @(posedge clk);
        check("midrst_noerr", 32'(err_cnt - e0), 32'd0);
        send_byte(8'h29, 0);
        check("after_rst", 32'(ps2_key), 32'h629);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
